// File: rtl/day_phase_scheduler_if.sv
// Handshake bundle between the traffic-mode controller and the day-phase sequencer.
interface day_phase_scheduler_if;
    logic       en;
    logic [7:0] lane_req;
    logic [7:0] light;
    logic [1:0] phase;
    logic       green;
    logic       clearing;
    logic       phase_start;

    modport master (
        output en, lane_req,
        input  light, phase, green, clearing, phase_start
    );

    modport slave (
        input  en, lane_req,
        output light, phase, green, clearing, phase_start
    );
endinterface

// File: rtl/day_phase_scheduler.sv
// Daytime light sequencer: round-robin over four lane-pair phases with
// demand skipping, min/max green bounds and all-red clearance between greens.
module day_phase_scheduler #(
    parameter int MIN_GREEN  = 4,
    parameter int MAX_GREEN  = 12,
    parameter int CLEAR_TIME = 2,
    parameter int TW         = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    day_phase_scheduler_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, GREEN, CLEAR} state_e;

    localparam logic [TW-1:0] MIN_T = TW'(MIN_GREEN);
    localparam logic [TW-1:0] MAX_T = TW'(MAX_GREEN);
    localparam logic [TW-1:0] CLR_T = TW'(CLEAR_TIME);

    state_e        state_q, state_d;
    logic [1:0]    phase_q, phase_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [7:0]    light_q, light_d;
    logic          start_q, start_d;

    logic [3:0]    preq;
    logic          other;
    logic          rr_hit;
    logic [1:0]    rr_idx;

    assign preq  = bus.lane_req[3:0] | bus.lane_req[7:4];
    assign other = |(preq & ~(4'b0001 << phase_q));

    // First requester after phase_q; scanning downward lets the nearest offset win.
    always_comb begin
        rr_hit = 1'b0;
        rr_idx = phase_q + 2'd1;
        for (int k = 4; k >= 1; k--) begin
            if (preq[phase_q + 2'(k)]) begin
                rr_hit = 1'b1;
                rr_idx = phase_q + 2'(k);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        timer_d = timer_q;
        case (state_q)
            IDLE: begin
                state_d = GREEN;
                phase_d = rr_hit ? rr_idx : 2'd0;
                timer_d = TW'(1);
            end
            GREEN: begin
                if (other && ((timer_q >= MIN_T && !preq[phase_q]) || timer_q >= MAX_T)) begin
                    state_d = CLEAR;
                    timer_d = TW'(1);
                end else if (timer_q < MAX_T) begin
                    timer_d = timer_q + TW'(1);
                end
            end
            CLEAR: begin
                if (timer_q >= CLR_T) begin
                    state_d = GREEN;
                    phase_d = rr_idx;
                    timer_d = TW'(1);
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase
        // Leaving day mode overrides everything but keeps the rotation position.
        if (!bus.en) begin
            state_d = IDLE;
            phase_d = phase_q;
            timer_d = '0;
        end
        light_d = (state_d == GREEN) ? (8'b0001_0001 << phase_d) : 8'h00;
        start_d = (state_d == GREEN) && (state_q != GREEN);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            phase_q <= 2'd3;
            timer_q <= '0;
            light_q <= 8'h00;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            timer_q <= timer_d;
            light_q <= light_d;
            start_q <= start_d;
        end
    end

    assign bus.light       = light_q;
    assign bus.phase       = phase_q;
    assign bus.green       = (state_q == GREEN);
    assign bus.clearing    = (state_q == CLEAR);
    assign bus.phase_start = start_q;
endmodule

// File: tb/tb_day_phase_scheduler.sv
// Self-checking bench for day_phase_scheduler: vector table, directed corner
// sequences and randomized traffic against a behavioural model.
module tb_day_phase_scheduler;
    localparam int MIN_G = 4;
    localparam int MAX_G = 12;
    localparam int CLR   = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    day_phase_scheduler_if bus();

    day_phase_scheduler #(
        .MIN_GREEN(MIN_G), .MAX_GREEN(MAX_G), .CLEAR_TIME(CLR), .TW(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int tests = 0;
    int fails = 0;

    // Model: mode 0 idle, 1 green, 2 clear; cnt = cycles spent in current mode.
    int m_mode, m_ph, m_cnt;

    typedef struct {
        logic       en;
        logic [7:0] req;
        logic [7:0] light;
        logic [1:0] ph;
        logic       g;
        logic       c;
        logic       ps;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
        end
    endtask

    function automatic int next_req(input int base, input logic [3:0] p, input int fallback);
        for (int k = 1; k <= 4; k++)
            if (p[(base + k) % 4]) return (base + k) % 4;
        return fallback;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_ph = 3; m_cnt = 0;
    endtask

    task automatic model_step(input logic en, input logic [7:0] req);
        logic [3:0] p;
        bit others;
        p = req[3:0] | req[7:4];
        others = 0;
        for (int q = 0; q < 4; q++)
            if (q != m_ph && p[q]) others = 1;
        if (!en) begin
            m_mode = 0; m_cnt = 0;
        end else if (m_mode == 0) begin
            m_ph = next_req(m_ph, p, 0); m_mode = 1; m_cnt = 1;
        end else if (m_mode == 1) begin
            if (others && ((m_cnt >= MIN_G && !p[m_ph]) || m_cnt >= MAX_G)) begin
                m_mode = 2; m_cnt = 1;
            end else if (m_cnt < MAX_G) begin
                m_cnt++;
            end
        end else begin
            if (m_cnt >= CLR) begin
                m_ph = next_req(m_ph, p, (m_ph + 1) % 4); m_mode = 1; m_cnt = 1;
            end else begin
                m_cnt++;
            end
        end
    endtask

    function automatic logic [12:0] model_outs();
        logic [7:0] l;
        l = (m_mode == 1) ? (8'h11 << m_ph) : 8'h00;
        return {l, 2'(m_ph), m_mode == 1, m_mode == 2, (m_mode == 1) && (m_cnt == 1)};
    endfunction

    function automatic logic [12:0] dut_outs();
        return {bus.light, bus.phase, bus.green, bus.clearing, bus.phase_start};
    endfunction

    // One clock with the given inputs; DUT compared to the model 1ns after the edge.
    task automatic cyc(input logic en, input logic [7:0] req, input string nm);
        bus.en = en;
        bus.lane_req = req;
        @(posedge clk);
        model_step(en, req);
        #1;
        check(nm, 32'(dut_outs()), 32'(model_outs()));
    endtask

    task automatic async_reset_check(input string nm);
        @(negedge clk);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check(nm, 32'(dut_outs()), {19'd0, 8'h00, 2'd3, 3'b000});
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        bus.en = 1'b0;
        bus.lane_req = 8'h00;
        model_reset();

        // Table: gap-out at MIN_GREEN, clearance, disable/re-enable.
        vecs[0] = '{1'b0, 8'hFF, 8'h00, 2'd3, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 8'h11, 8'h11, 2'd0, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{1'b1, 8'h33, 8'h11, 2'd0, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 8'h22, 8'h11, 2'd0, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 8'h22, 8'h11, 2'd0, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 8'h22, 8'h00, 2'd0, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{1'b1, 8'h22, 8'h00, 2'd0, 1'b0, 1'b1, 1'b0};
        vecs[7] = '{1'b1, 8'h22, 8'h22, 2'd1, 1'b1, 1'b0, 1'b1};
        vecs[8] = '{1'b0, 8'h22, 8'h00, 2'd1, 1'b0, 1'b0, 1'b0};
        vecs[9] = '{1'b1, 8'h00, 8'h11, 2'd0, 1'b1, 1'b0, 1'b1};

        #12;
        check("reset_state", 32'(dut_outs()), {19'd0, 8'h00, 2'd3, 3'b000});
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.en = vecs[i].en;
            bus.lane_req = vecs[i].req;
            @(posedge clk);
            model_step(vecs[i].en, vecs[i].req);
            #1;
            check($sformatf("vec%0d", i), 32'(dut_outs()),
                  {19'd0, vecs[i].light, vecs[i].ph, vecs[i].g, vecs[i].c, vecs[i].ps});
        end

        // Async reset mid-green with everything requesting, then first green is P0.
        for (int i = 0; i < 3; i++) cyc(1'b1, 8'hFF, "t1_pre");
        async_reset_check("t1_async_green");
        cyc(1'b1, 8'hFF, "t1_first");
        check("t1_first_light", 32'(bus.light), 32'h11);

        // Single phase requesting: rests in green, one start pulse, no clearance.
        async_reset_check("t2_reset");
        begin
            int starts = 0, clears = 0, badl = 0;
            for (int i = 0; i < 50; i++) begin
                cyc(1'b1, 8'h11, "t2_step");
                starts += int'(bus.phase_start);
                clears += int'(bus.clearing);
                if (bus.light != 8'h11) badl++;
            end
            check("t2_starts", 32'(starts), 32'd1);
            check("t2_clears", 32'(clears), 32'd0);
            check("t2_light_bad", 32'(badl), 32'd0);
        end

        // P0 and P2 both requesting: max-out alternation.
        async_reset_check("t3_reset");
        for (int i = 1; i <= 29; i++) begin
            logic [7:0] want;
            want = (i <= 12) ? 8'h11 : (i <= 14) ? 8'h00 : (i <= 26) ? 8'h44 :
                   (i <= 28) ? 8'h00 : 8'h11;
            cyc(1'b1, 8'h55, "t3_step");
            check($sformatf("t3_light_c%0d", i), 32'(bus.light), 32'(want));
        end

        // Wrap/skip from P3, then fallback to phase+1 with no requests.
        async_reset_check("t5_reset");
        for (int i = 0; i < 5; i++) cyc(1'b1, 8'h88, "t5_p3");
        check("t5_on_p3", 32'({bus.phase, bus.green}), {29'd0, 2'd3, 1'b1});
        for (int i = 0; i < 3; i++) cyc(1'b1, 8'h55, "t5_wrap");
        check("t5_wrap_p0", 32'({bus.phase, bus.green}), {29'd0, 2'd0, 1'b1});
        for (int i = 0; i < 4; i++) cyc(1'b1, 8'h22, "t5_gap");
        check("t5_clearing", 32'(bus.clearing), 32'd1);
        for (int i = 0; i < 2; i++) cyc(1'b1, 8'h00, "t5_none");
        check("t5_fallback", 32'({bus.phase, bus.green}), {29'd0, 2'd1, 1'b1});

        // Disable on green cycle 5, resume after retained phase, reset mid-clear.
        async_reset_check("t6_reset");
        for (int i = 0; i < 5; i++) cyc(1'b1, 8'h33, "t6_green");
        cyc(1'b0, 8'h33, "t6_off");
        check("t6_off_out", 32'({bus.light, bus.green}), 32'd0);
        cyc(1'b1, 8'h33, "t6_resume");
        check("t6_resume_ph", 32'({bus.phase, bus.light}), {22'd0, 2'd1, 8'h22});
        for (int i = 0; i < 12; i++) cyc(1'b1, 8'h33, "t6_max");
        check("t6_in_clear", 32'(bus.clearing), 32'd1);
        async_reset_check("t6_async_clear");

        // Randomized traffic against the model.
        begin
            logic [7:0] req = 8'h00;
            logic en;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(3) == 0) req = 8'($urandom);
                en = ($urandom_range(24) != 0);
                cyc(en, req, "rand");
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
